reg_file_dumper: RTL and testbench

//  Debug/trace reader for the 32x32 CPU register file: on a start pulse, walks every entry

---
 rtl/reg_file_dumper.sv | 80 ++++++++
 tb/tb_reg_file_dumper.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/reg_file_dumper.sv
// reg_file_dumper: walks the register file through one read port and streams {addr,data} beats.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum beat after the last entry.
module reg_file_dumper #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last
);
  typedef enum logic [1:0] {IDLE, STREAM, CSUM, DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam state_t AFTER = CSUM;
  localparam bit ENTRY_LAST = 1'b0;
`else
  localparam state_t AFTER = DONE;
  localparam bit ENTRY_LAST = 1'b1;
`endif
  state_t state, state_d;
  logic [ADDR_WIDTH:0] ptr;
  logic hs, load, last_hs, go;
  assign rf_raddr = ptr[ADDR_WIDTH-1:0];
  assign hs = out_valid & out_ready;
  assign go = (state == IDLE) & start;
  assign load = (state == STREAM) & (~out_valid | out_ready) & ~ptr[ADDR_WIDTH];
  // ptr MSB set means every entry is already loaded, so this is the final register beat
  assign last_hs = (state == STREAM) & hs & ptr[ADDR_WIDTH] & (out_addr == LAST);
  always_comb begin
    state_d = go ? STREAM : last_hs ? AFTER : (state == DONE) ? IDLE
            : (state == CSUM && hs) ? DONE : state;
    busy = (state == STREAM) | (state == CSUM);
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;
  always_ff @(posedge clk or negedge rst)
    if (!rst) csum <= '0;
    else if (go) csum <= '0;
    else if (load) csum <= csum ^ rf_rdata;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_addr <= '0;
      out_last <= 1'b0;
    end else if (go) begin
      ptr <= '0;
    end else if (load) begin
      out_data <= rf_rdata;
      out_addr <= ptr[ADDR_WIDTH-1:0];
      out_valid <= 1'b1;
      out_last <= ENTRY_LAST & (ptr[ADDR_WIDTH-1:0] == LAST);
      ptr <= ptr + (ADDR_WIDTH+1)'(1);
`ifdef REG_DUMP_CHECKSUM_EN
    end else if (last_hs) begin
      out_data <= csum;
      out_addr <= '0;
      out_last <= 1'b1;
`endif
    end else if (hs) begin
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end
  end
endmodule

// File: tb/tb_reg_file_dumper.sv
// tb_reg_file_dumper: directed and randomized dumps checked against a snapshot model of the register file.
module tb_reg_file_dumper;
  localparam int DW = 32, AW = 5, NE = 1 << AW;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int NB = NE + 1;
`else
  localparam int NB = NE;
`endif
  logic clk = 0, rst = 1, start = 0, out_ready = 0;
  logic busy, done, out_valid, out_last;
  logic [AW-1:0] rf_raddr, out_addr;
  logic [DW-1:0] rf_rdata, out_data;
  logic [DW-1:0] rf [NE];
  logic [DW-1:0] exp_d [NE];
  int n_vec = 0, n_err = 0, cyc = 0;
  logic [AW-1:0] got_a[$];
  logic [DW-1:0] got_d[$];
  logic got_l[$];
  int got_c[$];
  int done_q[$];
  logic pv = 0, pr = 0, pl = 0;
  logic [AW-1:0] pa = '0;
  logic [DW-1:0] pd = '0;

  reg_file_dumper #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rf_rdata = rf[rf_raddr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // a stalled beat must reappear unchanged on the next cycle
  always @(negedge clk) begin
    if (pv && !pr && rst) begin
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_data", 64'(out_data), 64'(pd));
      chk("stall_addr", 64'(out_addr), 64'(pa));
      chk("stall_last", 64'(out_last), 64'(pl));
    end
    if (out_valid && out_ready) begin
      got_a.push_back(out_addr);
      got_d.push_back(out_data);
      got_l.push_back(out_last);
      got_c.push_back(cyc);
    end
    if (done) done_q.push_back(cyc);
    pv = out_valid && rst;
    pr = out_ready;
    pd = out_data;
    pa = out_addr;
    pl = out_last;
  end

  task automatic clear_q();
    got_a.delete(); got_d.delete(); got_l.delete(); got_c.delete(); done_q.delete();
  endtask

  // mode 0: ready=1, 1: alternating, 2: random, 3: stall on beat 5 and write r5/r20
  task automatic dump(input int mode, input bit poke_busy, input bit poke_done, input string nm);
    int s;
    int stall = 0;
    logic [DW-1:0] x = '0;
    clear_q();
    for (int i = 0; i < NE; i++) exp_d[i] = rf[i];
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    s = cyc;
    chk({nm, "_busy_start"}, 64'(busy), 64'(1));
    for (int k = 0; k < 400; k++) begin
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'(k % 2 == 0) : 1'($urandom_range(0, 1));
      if (mode == 3) begin
        if (out_valid && out_addr == 5 && stall < 4) begin
          out_ready = 0;
          stall++;
          if (stall == 1) begin
            rf[5] = 32'hDEAD;
            rf[20] = 32'hBEEF;
            exp_d[20] = 32'hBEEF;
          end
        end else out_ready = 1;
      end
      start = (poke_busy && k == 8) || (poke_done && got_a.size() == NB && done_q.size() == 0);
      if (done_q.size() > 0) break;
      @(posedge clk); #1;
    end
    start = 0;
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_done_pulses"}, 64'(done_q.size()), 64'(1));
    chk({nm, "_idle_busy"}, 64'(busy), 64'(0));
    chk({nm, "_idle_valid"}, 64'(out_valid), 64'(0));
    chk({nm, "_beats"}, 64'(got_a.size()), 64'(NB));
    for (int i = 0; i < NE; i++) x ^= exp_d[i];
    for (int i = 0; i < NB && i < got_a.size(); i++) begin
      chk($sformatf("%s_addr%0d", nm, i), 64'(got_a[i]), 64'(i < NE ? i : 0));
      chk($sformatf("%s_data%0d", nm, i), 64'(got_d[i]), 64'(i < NE ? exp_d[i] : x));
      chk($sformatf("%s_last%0d", nm, i), 64'(got_l[i]), 64'(i == NB - 1));
    end
    if (got_a.size() == NB && done_q.size() == 1)
      chk({nm, "_done_time"}, 64'(done_q[0]), 64'(got_c[NB-1] + 1));
    if (mode == 0 && got_a.size() == NB) begin
      chk({nm, "_first_time"}, 64'(got_c[0]), 64'(s + 1));
      chk({nm, "_last_time"}, 64'(got_c[NB-1]), 64'(s + NB));
    end
    if (mode == 3) chk({nm, "_stalls"}, 64'(stall), 64'(4));
  endtask

  initial begin
    for (int i = 0; i < NE; i++) rf[i] = i == 0 ? '0 : DW'(32'h100 + i);
    #2 rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_addr", 64'(out_addr), 64'(0));
    chk("rst_last", 64'(out_last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_raddr", 64'(rf_raddr), 64'(0));
    rst = 1;
    dump(0, 0, 0, "t1");
    dump(1, 0, 0, "t2");
    dump(0, 1, 1, "t3");
    clear_q();
    @(posedge clk); #1 start = 1; out_ready = 1;
    @(posedge clk); #1 start = 0;
    for (int k = 0; k < 100 && got_a.size() < 11; k++) @(negedge clk);
    chk("t4_beats_before_rst", 64'(got_a.size()), 64'(11));
    @(posedge clk); #1 rst = 0;
    #1;
    chk("t4_rst_valid", 64'(out_valid), 64'(0));
    chk("t4_rst_busy", 64'(busy), 64'(0));
    chk("t4_rst_done", 64'(done), 64'(0));
    @(posedge clk); #1 rst = 1;
    dump(0, 0, 0, "t4");
    dump(3, 0, 0, "t5");
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i < NE; i++) rf[i] = $urandom;
      dump(2, 0, 0, $sformatf("rnd%0d", r));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
